// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Instruction fetch controller. It reads one instruction at a time from
//   instruction memory at the address held in an external PC register. It
//   hands the instruction to decode. It advances the PC by 4 or redirects
//   it to a target from execute.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   pc_in           current value of the external PC register
//   pc_ena          PC register write enable (single-cycle pulse)
//   pc_next         value the PC register loads while pc_ena=1
//   imem_req        instruction memory read request, held until imem_ack
//   imem_addr       instruction memory read address
//   imem_ack        instruction memory read acknowledge
//   imem_rdata      instruction memory read data, valid with imem_ack
//   inst_valid      instruction available to decode
//   inst            instruction word
//   inst_pc         address of inst
//   inst_ready      decode accepts the instruction
//   redirect        taken branch, jump or exception from execute
//   redirect_target new PC on redirect
//   fetch_err       sticky misaligned-PC flag, cleared by redirect
//   fetch_cnt       number of instructions delivered to decode (wraps)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_err,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_ADV   = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      r_state, w_state;
  logic        r_pc_ena, w_pc_ena;
  logic [31:0] r_pc_next, w_pc_next;
  logic        r_imem_req, w_imem_req;
  logic [31:0] r_imem_addr, w_imem_addr;
  logic        r_inst_valid, w_inst_valid;
  logic [31:0] r_inst, w_inst;
  logic [31:0] r_inst_pc, w_inst_pc;
  logic        r_fetch_err, w_fetch_err;
  logic [15:0] r_fetch_cnt, w_fetch_cnt;
  // A PC load requested while pc_ena is already high is parked here and
  // pulsed on the following cycle, so pc_ena is never high twice in a row.
  logic        r_pend, w_pend;
  logic        w_load;
  logic [31:0] w_load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc_ena     <= 1'b0;
      r_pc_next    <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= 32'd0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= RESET_PC;
      r_fetch_err  <= 1'b0;
      r_fetch_cnt  <= 16'd0;
      r_pend       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc_ena     <= w_pc_ena;
      r_pc_next    <= w_pc_next;
      r_imem_req   <= w_imem_req;
      r_imem_addr  <= w_imem_addr;
      r_inst_valid <= w_inst_valid;
      r_inst       <= w_inst;
      r_inst_pc    <= w_inst_pc;
      r_fetch_err  <= w_fetch_err;
      r_fetch_cnt  <= w_fetch_cnt;
      r_pend       <= w_pend;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_pc_ena     = 1'b0;
    w_pc_next    = r_pc_next;
    w_imem_req   = r_imem_req;
    w_imem_addr  = r_imem_addr;
    w_inst_valid = r_inst_valid;
    w_inst       = r_inst;
    w_inst_pc    = r_inst_pc;
    w_fetch_err  = r_fetch_err;
    w_fetch_cnt  = r_fetch_cnt;
    w_pend       = r_pend;
    w_load       = 1'b0;
    w_load_val   = r_pc_next;

    // Redirect wins over everything: the instruction in flight is dropped
    // and the error flag is cleared.
    if (redirect) begin
      w_load       = 1'b1;
      w_load_val   = redirect_target;
      w_inst_valid = 1'b0;
      w_fetch_err  = 1'b0;
    end

    case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_state = S_ADV;
        end else if (pc_in[1:0] != 2'b00) begin
          w_fetch_err = 1'b1;
          w_state     = S_ERR;
        end else begin
          w_imem_req  = 1'b1;
          w_imem_addr = pc_in;
          w_state     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (imem_ack) begin
            w_imem_req = 1'b0;
            w_state    = S_ADV;
          end else begin
            // Request stays open; its data is thrown away in S_DRAIN.
            w_state = S_DRAIN;
          end
        end else if (imem_ack) begin
          w_inst       = imem_rdata;
          w_inst_pc    = r_imem_addr;
          w_inst_valid = 1'b1;
          w_imem_req   = 1'b0;
          w_state      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_state = S_ADV;
        end else if (r_inst_valid && inst_ready) begin
          w_inst_valid = 1'b0;
          w_load       = 1'b1;
          w_load_val   = r_inst_pc + 32'd4;
          w_fetch_cnt  = r_fetch_cnt + 16'd1;
          w_state      = S_ADV;
        end
      end
      S_ADV: begin
        // Leave only once no PC load is outstanding, so S_REQ always sees
        // the updated PC register.
        if (redirect || r_pend) begin
          w_state = S_ADV;
        end else begin
          w_state = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          w_imem_req = 1'b0;
          w_state    = S_ADV;
        end
      end
      S_ERR: begin
        if (redirect) begin
          w_state = S_ADV;
        end
      end
      default: begin
        w_state    = S_REQ;
        w_imem_req = 1'b0;
      end
    endcase

    if (w_load) begin
      w_pc_next = w_load_val;
      if (r_pc_ena) begin
        w_pend = 1'b1;
      end else begin
        w_pc_ena = 1'b1;
        w_pend   = 1'b0;
      end
    end else if (r_pend) begin
      w_pc_ena = 1'b1;
      w_pend   = 1'b0;
    end
  end

  assign pc_ena     = r_pc_ena;
  assign pc_next    = r_pc_next;
  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fetch_err  = r_fetch_err;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
//   Directed bench for pc_fetch_ctrl. A small PC register model loads
//   pc_next on pc_ena and feeds pc_in. Every expected value is hand-computed.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_err;
  logic [15:0] fetch_cnt;

  logic        set_pc;
  logic [31:0] set_val;
  logic [31:0] pc_reg;

  int total = 0;
  int bad   = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h00400000)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_ena          (pc_ena),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_err       (fetch_err),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register
  always @(posedge clk) begin
    if (set_pc)      pc_reg <= set_val;
    else if (pc_ena) pc_reg <= pc_next;
  end
  assign pc_in = pc_reg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_ena"},   32'(pc_ena),     32'd0);
    chk({tag, "_req"},      32'(imem_req),   32'd0);
    chk({tag, "_valid"},    32'(inst_valid), 32'd0);
    chk({tag, "_err"},      32'(fetch_err),  32'd0);
    chk({tag, "_cnt"},      32'(fetch_cnt),  32'd0);
    chk({tag, "_inst"},     inst,            32'd0);
    chk({tag, "_addr"},     imem_addr,       32'd0);
    chk({tag, "_inst_pc"},  inst_pc,         32'h00400000);
    chk({tag, "_pc_next"},  pc_next,         32'h00400000);
  endtask

  initial begin
    rst = 1'b1; set_pc = 1'b1; set_val = 32'h00400000;
    imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b1;
    redirect = 1'b0; redirect_target = 32'd0;
    tick; tick;
    chk_reset_vals("rst0");

    // Sequential fetch
    rst = 1'b0; set_pc = 1'b0;
    tick;
    chk("seq_req",  32'(imem_req), 32'd1);
    chk("seq_addr", imem_addr, 32'h00400000);
    tick;
    chk("seq_wait_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h20080005;
    tick;
    imem_ack = 1'b0;
    chk("seq_valid",   32'(inst_valid), 32'd1);
    chk("seq_inst",    inst, 32'h20080005);
    chk("seq_inst_pc", inst_pc, 32'h00400000);
    chk("seq_req_off", 32'(imem_req), 32'd0);
    tick;
    chk("seq_pc_ena",  32'(pc_ena), 32'd1);
    chk("seq_pc_next", pc_next, 32'h00400004);
    chk("seq_cnt",     32'(fetch_cnt), 32'd1);
    chk("seq_vld_clr", 32'(inst_valid), 32'd0);
    tick;
    chk("seq_pc_ena_1cyc", 32'(pc_ena), 32'd0);
    tick;
    chk("seq_next_addr", imem_addr, 32'h00400004);

    // Backpressure
    inst_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hAAAA5555;
    tick;
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",   32'(inst_valid), 32'd1);
      chk("bp_inst",    inst, 32'hAAAA5555);
      chk("bp_inst_pc", inst_pc, 32'h00400004);
      chk("bp_no_ena",  32'(pc_ena), 32'd0);
      tick;
    end
    inst_ready = 1'b1;
    tick;
    chk("bp_pc_ena",  32'(pc_ena), 32'd1);
    chk("bp_pc_next", pc_next, 32'h00400008);
    chk("bp_cnt",     32'(fetch_cnt), 32'd2);
    tick;
    chk("bp_ena_off", 32'(pc_ena), 32'd0);
    tick;
    chk("bp_next_addr", imem_addr, 32'h00400008);

    // Redirect in S_WAIT before ack, late ack drained
    redirect = 1'b1; redirect_target = 32'h00400100;
    tick;
    redirect = 1'b0;
    chk("rdw_pc_ena",  32'(pc_ena), 32'd1);
    chk("rdw_pc_next", pc_next, 32'h00400100);
    chk("rdw_req_held", 32'(imem_req), 32'd1);
    tick;
    chk("rdw_ena_off", 32'(pc_ena), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick;
    imem_ack = 1'b0;
    chk("rdw_drop_valid", 32'(inst_valid), 32'd0);
    chk("rdw_req_off",    32'(imem_req), 32'd0);
    chk("rdw_no_ena",     32'(pc_ena), 32'd0);
    tick;
    tick;
    chk("rdw_new_addr", imem_addr, 32'h00400100);
    chk("rdw_cnt",      32'(fetch_cnt), 32'd2);

    // Redirect together with ack to a misaligned target
    redirect = 1'b1; redirect_target = 32'h00400002;
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    tick;
    redirect = 1'b0; imem_ack = 1'b0;
    chk("rda_valid",   32'(inst_valid), 32'd0);
    chk("rda_pc_next", pc_next, 32'h00400002);
    chk("rda_req_off", 32'(imem_req), 32'd0);
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("mis_err",    32'(fetch_err), 32'd1);
      chk("mis_no_req", 32'(imem_req), 32'd0);
      chk("mis_no_ena", 32'(pc_ena), 32'd0);
      tick;
    end
    redirect = 1'b1; redirect_target = 32'h00400180;
    tick;
    redirect = 1'b0;
    chk("mis_err_clr", 32'(fetch_err), 32'd0);
    chk("mis_pc_ena",  32'(pc_ena), 32'd1);
    chk("mis_pc_next", pc_next, 32'h00400180);
    tick;
    tick;
    chk("mis_resume_req",  32'(imem_req), 32'd1);
    chk("mis_resume_addr", imem_addr, 32'h00400180);

    // Redirect during the pc_ena cycle of S_ADV is deferred one cycle
    imem_ack = 1'b1; imem_rdata = 32'h11111111;
    tick;
    imem_ack = 1'b0;
    tick;
    chk("adv_pc_next", pc_next, 32'h00400184);
    chk("adv_cnt",     32'(fetch_cnt), 32'd3);
    redirect = 1'b1; redirect_target = 32'hFFFFFFFC;
    tick;
    redirect = 1'b0;
    chk("adv_no_back2back", 32'(pc_ena), 32'd0);
    tick;
    chk("adv_late_ena",  32'(pc_ena), 32'd1);
    chk("adv_late_next", pc_next, 32'hFFFFFFFC);
    tick;
    tick;
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);

    // Address and counter wrap
    force dut.r_fetch_cnt = 16'hFFFF;
    #1;
    release dut.r_fetch_cnt;
    imem_ack = 1'b1; imem_rdata = 32'h22222222;
    tick;
    imem_ack = 1'b0;
    chk("wrap_inst_pc", inst_pc, 32'hFFFFFFFC);
    tick;
    chk("wrap_pc_ena",  32'(pc_ena), 32'd1);
    chk("wrap_pc_next", pc_next, 32'h00000000);
    chk("wrap_cnt",     32'(fetch_cnt), 32'd0);
    tick;
    tick;
    chk("wrap_fetch0", imem_addr, 32'h00000000);
    chk("wrap_req",    32'(imem_req), 32'd1);

    // Asynchronous reset between edges while a request is open
    #3;
    rst = 1'b1; set_pc = 1'b1; set_val = 32'h00400000;
    #1;
    chk_reset_vals("arst");
    tick; tick;
    chk("arst_hold_ena", 32'(pc_ena), 32'd0);
    rst = 1'b0; set_pc = 1'b0;
    tick;
    chk("arst_first_req",  32'(imem_req), 32'd1);
    chk("arst_first_addr", imem_addr, 32'h00400000);

    // Redirect together with inst_ready in S_HOLD
    inst_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h33333333;
    tick;
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_target = 32'h00400200; inst_ready = 1'b1;
    tick;
    redirect = 1'b0; inst_ready = 1'b0;
    chk("rdh_pc_ena",  32'(pc_ena), 32'd1);
    chk("rdh_pc_next", pc_next, 32'h00400200);
    chk("rdh_cnt",     32'(fetch_cnt), 32'd0);
    chk("rdh_valid",   32'(inst_valid), 32'd0);
    tick;
    tick;
    chk("rdh_new_addr", imem_addr, 32'h00400200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000: address reported on inst_pc and pc_next after reset.
REQ-002 SHALL have ports: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports: pc_in  input  32  current value of the PC register.
REQ-005 SHALL have ports: pc_ena  output  1  PC register write enable, one-cycle pulse.
REQ-006 SHALL have ports: pc_next  output  32  value the PC register loads when pc_ena=1.
REQ-007 SHALL have ports: imem_req  output  1, imem_addr  output  32, imem_ack  input  1, imem_rdata  input  32  instruction memory read handshake.
REQ-008 SHALL have ports: inst_valid  output  1, inst  output  32, inst_pc  output  32, inst_ready  input  1  instruction handoff to decode.
REQ-009 SHALL have ports: redirect  input  1, redirect_target  input  32  taken branch, jump or exception from execute.
REQ-010 SHALL have ports: fetch_err  output  1  sticky misaligned-PC flag; fetch_cnt  output  16  count of delivered instructions.

Function
REQ-011 SHALL implement states S_REQ, S_WAIT, S_HOLD, S_ADV, S_DRAIN, S_ERR.
REQ-012 S_REQ: if pc_in[1:0]!=0, SHALL set fetch_err=1 and go to S_ERR with no request; otherwise SHALL drive imem_req=1 and imem_addr=pc_in, then go to S_WAIT.
REQ-013 S_WAIT: SHALL hold imem_req=1 and imem_addr stable until imem_ack=1. On ack: latch inst=imem_rdata and inst_pc=imem_addr, set inst_valid=1, drop imem_req, go to S_HOLD.
REQ-014 S_HOLD: inst, inst_pc and inst_valid SHALL stay stable until inst_ready=1.
REQ-015 On inst_valid & inst_ready, SHALL in the same edge: clear inst_valid, pulse pc_ena for exactly one cycle with pc_next=inst_pc+4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0), increment fetch_cnt (wraps 16'hFFFF to 0), go to S_ADV.
REQ-016 S_ADV: SHALL last exactly one cycle so the PC register can update, then go to S_REQ.
REQ-017 redirect=1 has priority over every other event in every state.
REQ-018 On redirect, SHALL pulse pc_ena with pc_next=redirect_target, clear inst_valid and leave fetch_cnt unchanged.
REQ-019 Redirect next state SHALL be: from S_WAIT without imem_ack, S_DRAIN; from any other state, S_ADV.
REQ-020 S_DRAIN: SHALL keep imem_req=1 until imem_ack, discard imem_rdata, then go to S_ADV; a redirect during S_DRAIN only updates pc_next/pc_ena.
REQ-021 redirect together with imem_ack in S_WAIT: data SHALL be discarded, go directly to S_ADV.
REQ-022 redirect together with inst_ready in S_HOLD: instruction not counted; pc_next=redirect_target.
REQ-023 S_ERR: SHALL issue no requests and no pc_ena until redirect; redirect clears fetch_err and follows REQ-018 and REQ-019.
REQ-024 pc_ena SHALL never be high on two consecutive cycles.
REQ-025 At most one memory request SHALL be outstanding at any time.

Reset
REQ-026 While rst=1, SHALL immediately force: state=S_REQ, pc_ena=0, imem_req=0, inst_valid=0, fetch_err=0, fetch_cnt=0, inst=0, imem_addr=0, inst_pc=RESET_PC, pc_next=RESET_PC.
REQ-027 Reset asserted mid-transaction SHALL abandon it without pulsing pc_ena.
REQ-028 After reset release, the first request SHALL be issued on the first rising edge.
REQ-029 An imem_ack that arrives after reset for a request abandoned by reset is the memory's responsibility and is not filtered.

Verification
REQ-030 Sequential fetch: pc_in=32'h00400000, ack after 2 cycles with 32'h20080005, inst_ready=1 -> inst_valid=1, inst_pc=32'h00400000, single pc_ena with pc_next=32'h00400004, fetch_cnt=1.
REQ-031 Backpressure: inst_ready=0 for 5 cycles -> inst and inst_pc stable, no pc_ena; ready at cycle 6 -> one pc_ena.
REQ-032 Redirect in S_WAIT: redirect with target 32'h00400100 before ack -> pc_ena with pc_next=32'h00400100; the late ack data never reaches inst_valid; next imem_addr=32'h00400100.
REQ-033 Misaligned PC: pc_in=32'h00400002 -> fetch_err=1, imem_req stays 0; redirect to 32'h00400180 -> fetch_err=0, fetching resumes.
REQ-034 Wrap: inst_pc=32'hFFFFFFFC accepted -> pc_next=32'h00000000; fetch_cnt at 16'hFFFF increments to 0.
REQ-035 Async reset while imem_req=1 and asserted between clock edges -> outputs take REQ-026 values before the next edge.
